mul_iter: RTL
=============

# mul_iter

Iterative 64×64 multiplier sitting between the register file read ports and the write-back path of the LEGv8 datapath. Accepts two 64-bit operands (ReadData1/ReadData2), a destination register number and an operation select. Computes MUL, SMULH or UMULH with a radix-2 shift-add engine, then issues a one-cycle write request (WriteData / WriteRegister / RegWrite) toward the register file. The pipeline control stalls on `busy`.

## Interface
- Parameters: none. Width is fixed at 64 bits and iteration count at 64.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` — input, 1 bit. Rising-edge clock.
- `reset_n` — input, 1 bit. Asynchronous, active-low reset.
- `start` — input, 1 bit. Request a multiply. Sampled only in IDLE.
- `flush` — input, 1 bit. Synchronous abort of any in-flight operation.
- `op` — input, 2 bits. Operation select, using `mul_pkg::mul_op_t`:
  - 00 MUL: low 64 bits of the product.
  - 01 SMULH: high 64 bits of the signed product.
  - 10 UMULH: high 64 bits of the unsigned product.
  - 11: treated as MUL.
- `a`, `b` — input, 64 bits each. Operands (ReadData1, ReadData2).
- `rd` — input, 5 bits. Destination register.
- `busy` — output, 1 bit. High whenever state ≠ IDLE.
- `done` — output, 1 bit. One-cycle pulse when the result is valid.
- `WriteData` — output, 64 bits. Result. Held from DONE until the next accepted start.
- `WriteRegister` — output, 5 bits. Latched `rd`.
- `RegWrite` — output, 1 bit. `done && (WriteRegister != 31)`.

## Operation
- States (`mul_pkg::mul_state_t`): IDLE, CALC, FIX, DONE.
- IDLE with `start` = 1:
  - Latch `op` and `rd`.
  - For SMULH, latch |a| and |b| as magnitudes and record `neg` = a[63] ^ b[63]. Otherwise latch a and b raw, with `neg` = 0.
  - Clear the 128-bit accumulator and the 6-bit counter, then go to CALC.
- CALC: each cycle, if multiplier bit 0 = 1, add the multiplicand (zero-extended to 128 bits, shifted by the count) into the accumulator. Then shift the multiplier right by 1 and increment the counter. After the 64th iteration (counter wraps 63→0), go to FIX.
- FIX:
  - If `neg`, the accumulator becomes its two's-complement negation.
  - Select `WriteData` = acc[63:0] for MUL, acc[127:64] otherwise.
  - Go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- MUL low bits are sign-agnostic, so no sign handling is applied.
- Magnitude of 0x8000_0000_0000_0000 is 2^63 and must be handled as unsigned 64-bit (no overflow).
- `start` outside IDLE is ignored, including in DONE. No queueing.
- `flush` in any state: next state is IDLE, no `done`, `WriteData`/`WriteRegister` unchanged. `flush` has priority over `start` in IDLE.
- `rd` = 31 (XZR): `done` still pulses, `RegWrite` stays 0.

## Timing
- Reset values (asynchronous, immediate on `reset_n` low):
  - State IDLE.
  - `busy`, `done`, `RegWrite` = 0.
  - `WriteData` = 0, `WriteRegister` = 0.
  - Accumulator, counter and `neg` = 0.
- Reset mid-operation: the operation is discarded and no `done` is issued after `reset_n` is released.
- Latency, with the start accepted at edge E0:
  - `busy` is high from E0.
  - CALC iterations complete at E1..E64.
  - FIX is entered after E64; DONE after E65.
  - `done`/`RegWrite` are high in the cycle after E65.
  - Back in IDLE after E66.
- Start-to-done latency is 66 cycles.
- Minimum start-to-start spacing is 67 cycles.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.

## Structure
- `mul_pkg`: `mul_op_t` enum, `mul_state_t` enum, `MUL_WIDTH` = 64, `ZERO_REG` = 5'd31.
- One sub-module: `negate64`, the 64-bit two's-complement unit used for operand magnitude. The FIX-stage 128-bit negation uses two chained `negate64` instances with borrow-in, or inline logic.
- The accumulator/adder is inline in `mul_iter`.

## Test plan
- MUL, a = 3, b = 5, rd = 2: `done` 66 cycles after start; `WriteData` = 15, `WriteRegister` = 2, `RegWrite` = 1; `busy` low the following cycle.
- SMULH, a = 0xFFFF_FFFF_FFFF_FFFF (−1), b = 1: `WriteData` = 0xFFFF_FFFF_FFFF_FFFF. Then SMULH with a = b = 0x8000_0000_0000_0000: `WriteData` = 0x4000_0000_0000_0000.
- UMULH, a = 0xFFFF_FFFF_FFFF_FFFF, b = 2: `WriteData` = 1. MUL of the same operands: `WriteData` = 0xFFFF_FFFF_FFFF_FFFE.
- MUL, a = 7, b = 6, rd = 31: `done` pulses, `RegWrite` = 0, `WriteData` = 42.
- Start a MUL, assert `start` with different operands at cycles 10 and 65: both ignored, and the first result is correct. Assert `flush` at cycle 30 of a second op: IDLE next cycle, no `done`, `WriteData` still holds the prior result.
- Pull `reset_n` low at cycle 40 of an op: all outputs 0 immediately; after release, no `done` appears within 100 cycles; a new MUL 2×2 then returns 4.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative LEGv8 multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 64;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_SMULH = 2'b01,
        OP_UMULH = 2'b10,
        OP_RSVD  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mul_state_t;

    // The reserved encoding behaves as a plain low-half multiply.
    function automatic mul_op_t norm_op(input mul_op_t o);
        return (o == OP_SMULH || o == OP_UMULH) ? o : OP_MUL;
    endfunction

endpackage

// File: rtl/negate64.sv
// 64-bit two's-complement slice; cin=1 for a standalone negate,
// cin=borrow from the lower half when chained into wider words.
module negate64
    import mul_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] x,
    input  logic                 cin,
    output logic [MUL_WIDTH-1:0] y
);

    assign y = ~x + {{(MUL_WIDTH-1){1'b0}}, cin};

endmodule

// File: rtl/mul_iter.sv
// Radix-2 shift-add 64x64 multiplier (MUL/SMULH/UMULH) with a
// one-cycle register-file write request on completion.
module mul_iter
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 flush,
    input  mul_op_t              op,
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic [4:0]           rd,
    output logic                 busy,
    output logic                 done,
    output logic [MUL_WIDTH-1:0] WriteData,
    output logic [4:0]           WriteRegister,
    output logic                 RegWrite
);

    mul_state_t state;
    mul_state_t state_nxt;

    mul_op_t                 op_q;
    logic [4:0]              rd_q;
    logic [MUL_WIDTH-1:0]    mcand;
    logic [MUL_WIDTH-1:0]    mplier;
    logic [2*MUL_WIDTH-1:0]  acc;
    logic [5:0]              cnt;
    logic                    neg;

    logic [MUL_WIDTH-1:0]    a_neg;
    logic [MUL_WIDTH-1:0]    b_neg;
    logic [MUL_WIDTH-1:0]    a_mag;
    logic [MUL_WIDTH-1:0]    b_mag;
    logic [2*MUL_WIDTH-1:0]  addend;
    logic [MUL_WIDTH-1:0]    acc_neg_lo;
    logic [MUL_WIDTH-1:0]    acc_neg_hi;
    logic                    lo_borrow;
    logic [2*MUL_WIDTH-1:0]  acc_fix;

    negate64 u_neg_a (
        .x   (a),
        .cin (1'b1),
        .y   (a_neg)
    );

    negate64 u_neg_b (
        .x   (b),
        .cin (1'b1),
        .y   (b_neg)
    );

    // 0x8000... negates to itself, which read unsigned is exactly 2^63.
    assign a_mag = a[MUL_WIDTH-1] ? a_neg : a;
    assign b_mag = b[MUL_WIDTH-1] ? b_neg : b;

    // The +1 only ripples into the upper half when the lower half is zero.
    assign lo_borrow = (acc[MUL_WIDTH-1:0] == '0);

    negate64 u_neg_lo (
        .x   (acc[MUL_WIDTH-1:0]),
        .cin (1'b1),
        .y   (acc_neg_lo)
    );

    negate64 u_neg_hi (
        .x   (acc[2*MUL_WIDTH-1:MUL_WIDTH]),
        .cin (lo_borrow),
        .y   (acc_neg_hi)
    );

    assign acc_fix = neg ? {acc_neg_hi, acc_neg_lo} : acc;
    assign addend  = {{MUL_WIDTH{1'b0}}, mcand} << cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_CALC;
            S_CALC: if (cnt == 6'd63) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        RegWrite = (state == S_DONE) && (WriteRegister != ZERO_REG);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q          <= OP_MUL;
            rd_q          <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
            WriteData     <= '0;
            WriteRegister <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q <= norm_op(op);
                        rd_q <= rd;
                        acc  <= '0;
                        cnt  <= '0;
                        if (op == OP_SMULH) begin
                            mcand  <= a_mag;
                            mplier <= b_mag;
                            neg    <= a[MUL_WIDTH-1] ^ b[MUL_WIDTH-1];
                        end else begin
                            mcand  <= a;
                            mplier <= b;
                            neg    <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    if (mplier[0]) acc <= acc + addend;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                end
                S_FIX: begin
                    if (!flush) begin
                        acc           <= acc_fix;
                        WriteRegister <= rd_q;
                        if (op_q == OP_MUL)
                            WriteData <= acc_fix[MUL_WIDTH-1:0];
                        else
                            WriteData <= acc_fix[2*MUL_WIDTH-1:MUL_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
